// File: rtl/ac97_pkg.sv
// Shared constants for the AC'97 command scheduler: codec register
// addresses, init table length, FSM states and the volume encoder.
package ac97_pkg;

  localparam logic [6:0] REG_MASTER  = 7'h02;
  localparam logic [6:0] REG_HP      = 7'h04;
  localparam logic [6:0] REG_LINE_IN = 7'h10;
  localparam logic [6:0] REG_PCM_OUT = 7'h18;
  localparam logic [6:0] REG_REC_SEL = 7'h1A;

  localparam int INIT_LEN = 5;

  localparam logic [15:0] PCM_OUT_GAIN = 16'h0808;
  localparam logic [15:0] REC_SEL_MIC  = 16'h0000;

  typedef enum logic [2:0] {
    WAIT_READY,
    INIT_ISSUE,
    INIT_WAIT,
    RUN_IDLE,
    RUN_WAIT
  } state_t;

  // Codec volume fields are attenuation, so a louder setting
  // maps to a smaller field value on both channels.
  function automatic logic [15:0] vol_word(input logic [4:0] vol);
    logic [4:0] att;
    att = 5'd31 - vol;
    return {3'b000, att, 3'b000, att};
  endfunction

endpackage

// File: rtl/ac97_rr_arbiter.sv
// Two-way round-robin arbiter with an internal priority pointer.
// Ports: clk, rst, clear, en, req[1:0] in; gnt[1:0] one-hot out.
module ac97_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // The pointer flips on every grant, whoever won it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_q <= 1'b0;
    end else if (|gnt) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// Issues the codec init table, then arbitrates two register writers.
// Ports: CLK/Rst, codec_ready, done in; validate/Register/command out;
// req0/req1 valid/addr/data in, ack out; init_done, busy, timeout_err.
module ac97_cmd_scheduler
  import ac97_pkg::*;
#(
  parameter logic [4:0]  MasterVolume  = 5'd22,
  parameter logic [4:0]  HPVolume      = 5'd22,
  parameter logic [4:0]  LineInVolume  = 5'd22,
  parameter logic [15:0] TimeoutCycles = 16'd4096
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        codec_ready,
  input  logic        done,
  output logic        validate,
  output logic [7:0]  Register,
  output logic [15:0] command,
  input  logic        req0_valid,
  input  logic [6:0]  req0_addr,
  input  logic [15:0] req0_data,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [6:0]  req1_addr,
  input  logic [15:0] req1_data,
  output logic        req1_ack,
  output logic        init_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] LAST = 3'(INIT_LEN - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        val_q, val_d;
  logic [7:0]  reg_q, reg_d;
  logic [15:0] cmd_q, cmd_d;
  logic [1:0]  ack_q, ack_d;
  logic        idone_q, idone_d;
  logic        terr_q, terr_d;
  logic        gsel_q, gsel_d;

  logic [6:0]  init_addr;
  logic [15:0] init_data;
  logic [1:0]  gnt;
  logic        arb_en;
  logic        tmo;

  always_comb begin
    init_addr = REG_MASTER;
    init_data = vol_word(MasterVolume);
    case (idx_q)
      3'd1: begin
        init_addr = REG_HP;
        init_data = vol_word(HPVolume);
      end
      3'd2: begin
        init_addr = REG_LINE_IN;
        init_data = vol_word(LineInVolume);
      end
      3'd3: begin
        init_addr = REG_PCM_OUT;
        init_data = PCM_OUT_GAIN;
      end
      3'd4: begin
        init_addr = REG_REC_SEL;
        init_data = REC_SEL_MIC;
      end
      default: ;
    endcase
  end

  // No grant during the ack cycle: the acked requester is
  // still holding valid until it sees the pulse.
  assign arb_en = (state_q == RUN_IDLE) && codec_ready
                && (ack_q == 2'b00);

  ac97_rr_arbiter u_arb (
    .clk   (CLK),
    .rst   (Rst),
    .clear (~codec_ready),
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign tmo = (cnt_q == TimeoutCycles - 16'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    reg_d   = reg_q;
    cmd_d   = cmd_q;
    ack_d   = 2'b00;
    idone_d = idone_q;
    terr_d  = terr_q;
    gsel_d  = gsel_q;
    if (!codec_ready) begin
      state_d = WAIT_READY;
      idx_d   = 3'd0;
      cnt_d   = 16'd0;
      val_d   = 1'b0;
      idone_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_READY: begin
          state_d = INIT_ISSUE;
          idx_d   = 3'd0;
        end
        INIT_ISSUE: begin
          val_d   = 1'b1;
          reg_d   = {1'b0, init_addr};
          cmd_d   = init_data;
          cnt_d   = 16'd0;
          state_d = INIT_WAIT;
        end
        INIT_WAIT: begin
          if (done || tmo) begin
            val_d = 1'b0;
            if (!done) terr_d = 1'b1;
            if (idx_q == LAST) begin
              idone_d = 1'b1;
              idx_d   = 3'd0;
              state_d = RUN_IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = INIT_ISSUE;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RUN_IDLE: begin
          if (|gnt) begin
            val_d   = 1'b1;
            gsel_d  = gnt[1];
            reg_d   = {1'b0, gnt[1] ? req1_addr : req0_addr};
            cmd_d   = gnt[1] ? req1_data : req0_data;
            cnt_d   = 16'd0;
            state_d = RUN_WAIT;
          end
        end
        RUN_WAIT: begin
          if (done || tmo) begin
            val_d   = 1'b0;
            if (!done) terr_d = 1'b1;
            ack_d   = gsel_q ? 2'b10 : 2'b01;
            state_d = RUN_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = WAIT_READY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q <= WAIT_READY;
      idx_q   <= 3'd0;
      cnt_q   <= 16'd0;
      val_q   <= 1'b0;
      reg_q   <= 8'h00;
      cmd_q   <= 16'h0000;
      ack_q   <= 2'b00;
      idone_q <= 1'b0;
      terr_q  <= 1'b0;
      gsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      reg_q   <= reg_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      idone_q <= idone_d;
      terr_q  <= terr_d;
      gsel_q  <= gsel_d;
    end
  end

  assign validate    = val_q;
  assign busy        = val_q;
  assign Register    = reg_q;
  assign command     = cmd_q;
  assign req0_ack    = ack_q[0];
  assign req1_ack    = ack_q[1];
  assign init_done   = idone_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Directed + randomized bench for ac97_cmd_scheduler with a
// command-level reference model (init table, round-robin, timeout).
module tb_ac97_cmd_scheduler;

  logic        CLK = 1'b0;
  logic        Rst;
  logic        codec_ready;
  logic        done;
  logic        validate;
  logic [7:0]  Register;
  logic [15:0] command;
  logic        req0_valid;
  logic [6:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req0_ack;
  logic        req1_valid;
  logic [6:0]  req1_addr;
  logic [15:0] req1_data;
  logic        req1_ack;
  logic        init_done;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int passed = 0;
  int ptr = 0;
  bit terr_m = 1'b0;

  logic [6:0]  init_addr [5];
  logic [15:0] init_data [5];

  always #5 CLK = ~CLK;

  ac97_cmd_scheduler #(
    .TimeoutCycles (16'd16)
  ) dut (
    .CLK         (CLK),
    .Rst         (Rst),
    .codec_ready (codec_ready),
    .done        (done),
    .validate    (validate),
    .Register    (Register),
    .command     (command),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ack    (req0_ack),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ack    (req1_ack),
    .init_done   (init_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  function automatic logic [15:0] volw(input int v);
    int a;
    a = (31 - v) & 31;
    return 16'(a * 257);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (validate === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // k = cycles after the first validate-high sample at which done is
  // driven; k > 15 means done is withheld and the timeout must fire.
  task automatic do_cmd(input string tag, input logic [7:0] er,
                        input logic [15:0] ec, input int k,
                        input int who);
    bit ok;
    bit stable;
    int j;
    logic [1:0] eack;
    wait_valid(ok);
    chk({tag, "_issue"}, 32'(ok), 32'd1);
    if (!ok) return;
    chk({tag, "_reg"}, 32'(Register), 32'(er));
    chk({tag, "_cmd"}, 32'(command), 32'(ec));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    stable = 1'b1;
    j = 0;
    forever begin
      if (j == k) done = 1'b1;
      if (who == 0) begin
        req0_addr = 7'($urandom);
        req0_data = 16'($urandom);
      end
      if (who == 1) begin
        req1_addr = 7'($urandom);
        req1_data = 16'($urandom);
      end
      @(negedge CLK);
      done = 1'b0;
      if (j == k || j == 15) break;
      if (validate !== 1'b1 || Register !== er || command !== ec)
        stable = 1'b0;
      j++;
    end
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    chk({tag, "_fall"}, 32'(validate), 32'd0);
    terr_m = terr_m | (k > 15);
    chk({tag, "_terr"}, 32'(timeout_err), 32'(terr_m));
    eack = (who < 0) ? 2'b00 : (who == 0) ? 2'b01 : 2'b10;
    chk({tag, "_ack"}, 32'({req1_ack, req0_ack}), 32'(eack));
    if (who >= 0) begin
      if (who == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
      @(negedge CLK);
      chk({tag, "_ackw"}, 32'({req1_ack, req0_ack}), 32'd0);
    end
  endtask

  task automatic run_init(input string tag, input int k0, input int kk);
    for (int i = 0; i < 5; i++) begin
      do_cmd($sformatf("%s%0d", tag, i), {1'b0, init_addr[i]},
             init_data[i], (i == 0) ? k0 : kk, -1);
      chk($sformatf("%s%0d_idone", tag, i), 32'(init_done),
          (i == 4) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic run_one(input string tag, input int k);
    int w;
    logic [7:0] er;
    logic [15:0] ec;
    if (req0_valid && req1_valid) w = ptr;
    else w = req1_valid ? 1 : 0;
    ptr ^= 1;
    er = {1'b0, (w == 1) ? req1_addr : req0_addr};
    ec = (w == 1) ? req1_data : req0_data;
    do_cmd(tag, er, ec, k, w);
  endtask

  task automatic raise(input int who, input logic [6:0] a);
    if (who == 0) begin
      req0_valid = 1'b1;
      req0_addr = a;
      req0_data = 16'($urandom);
    end else begin
      req1_valid = 1'b1;
      req1_addr = a;
      req1_data = 16'($urandom);
    end
  endtask

  initial begin
    bit ok;
    bit seen;
    logic [7:0] er;
    logic [15:0] ec;
    init_addr[0] = 7'h02; init_data[0] = volw(22);
    init_addr[1] = 7'h04; init_data[1] = volw(22);
    init_addr[2] = 7'h10; init_data[2] = volw(22);
    init_addr[3] = 7'h18; init_data[3] = 16'h0808;
    init_addr[4] = 7'h1A; init_data[4] = 16'h0000;
    Rst = 1'b1;
    codec_ready = 1'b0;
    done = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_validate", 32'(validate), 32'd0);
    chk("rst_reg", 32'(Register), 32'h00);
    chk("rst_cmd", 32'(command), 32'h0000);
    chk("rst_idone", 32'(init_done), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_acks", 32'({req1_ack, req0_ack}), 32'd0);
    Rst = 1'b0;
    repeat (2) @(negedge CLK);
    chk("wait_ready_idle", 32'(validate), 32'd0);
    codec_ready = 1'b1;
    run_init("init", 10, 10);

    raise(0, 7'h02);
    raise(1, 7'h04);
    run_one("rr_a", 2);
    raise(0, 7'h02);
    run_one("rr_b", 5);
    raise(1, 7'h04);
    run_one("rr_c", 0);

    run_one("coincident", 15);
    chk("coincident_terr0", 32'(timeout_err), 32'd0);

    raise(1, 7'($urandom));
    er = {1'b0, req1_addr};
    ec = req1_data;
    ptr ^= 1;
    wait_valid(ok);
    chk("drop_issue", 32'(ok), 32'd1);
    chk("drop_reg", 32'(Register), 32'(er));
    chk("drop_cmd", 32'(command), 32'(ec));
    repeat (3) @(negedge CLK);
    codec_ready = 1'b0;
    @(negedge CLK);
    chk("drop_validate", 32'(validate), 32'd0);
    chk("drop_idone", 32'(init_done), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      if (req1_ack === 1'b1) seen = 1'b1;
      @(negedge CLK);
    end
    chk("drop_no_ack", 32'(seen), 32'd0);
    req1_valid = 1'b0;
    codec_ready = 1'b1;
    ptr = 0;
    run_init("reinit", 20, 3);

    for (int it = 0; it < 24; it++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1)
        raise(0, 7'($urandom));
      if (!req1_valid && $urandom_range(0, 1) == 1)
        raise(1, 7'($urandom));
      if (!req0_valid && !req1_valid)
        raise(int'($urandom_range(0, 1)), 7'($urandom));
      run_one($sformatf("rnd%0d", it), int'($urandom_range(0, 17)));
    end

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    codec_ready = 1'b0;
    @(negedge CLK);
    chk("cycle_idone", 32'(init_done), 32'd0);
    codec_ready = 1'b1;
    do_cmd("pre0", {1'b0, init_addr[0]}, init_data[0], 2, -1);
    do_cmd("pre1", {1'b0, init_addr[1]}, init_data[1], 2, -1);
    wait_valid(ok);
    chk("pre2_issue", 32'(ok), 32'd1);
    chk("pre2_reg", 32'(Register), 32'({1'b0, init_addr[2]}));
    chk("pre2_terr", 32'(timeout_err), 32'(terr_m));
    Rst = 1'b1;
    @(negedge CLK);
    chk("mid_validate", 32'(validate), 32'd0);
    chk("mid_reg", 32'(Register), 32'h00);
    chk("mid_cmd", 32'(command), 32'h0000);
    chk("mid_terr", 32'(timeout_err), 32'd0);
    chk("mid_idone", 32'(init_done), 32'd0);
    Rst = 1'b0;
    terr_m = 1'b0;
    ptr = 0;
    run_init("rst", 4, 4);
    raise(0, 7'h11);
    raise(1, 7'h22);
    run_one("post_rst", 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_scheduler.md
AC97_CMD_SCHEDULER -- requirements
Module: ac97_cmd_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  MasterVolume  5'd22  master output volume; a larger value is louder.
  HPVolume  5'd22  headphone volume.
  LineInVolume  5'd22  line-in gain.
  TimeoutCycles  16'd4096  CLK cycles to wait for done before abandoning a command.
REQ-002 Ports, one per line: name, direction, width, meaning.
  CLK  in  1  system clock, 100 MHz; the only clock.
  Rst  in  1  synchronous, active-high reset.
  codec_ready  in  1  high once the codec reset (AC97Rstn) is released.
  done  in  1  one-cycle pulse, CLK-synchronous: controller consumed the current command.
  validate  out  1  command present toward the controller.
  Register  out  8  [7] = read/write (0 = write), [6:0] = register address.
  command  out  16  register write data.
  req0_valid  in  1  requester 0 holds a write pending.
  req0_addr  in  7  requester 0 register address.
  req0_data  in  16  requester 0 write data.
  req0_ack  out  1  one-cycle pulse: requester 0 command finished.
  req1_valid, req1_addr, req1_data, req1_ack  same widths and meaning, for requester 1.
  init_done  out  1  init table completed.
  busy  out  1  a command is outstanding.
  timeout_err  out  1  sticky: at least one command timed out.

Function
REQ-003 The FSM has five states: WAIT_READY, INIT_ISSUE, INIT_WAIT, RUN_IDLE, RUN_WAIT.
REQ-004 WAIT_READY: validate=0 and init_done=0. Go to INIT_ISSUE one cycle after codec_ready is sampled high.
REQ-005 The init table has 5 entries, issued in order: 0x02 master, 0x04 headphone, 0x10 line-in, 0x18 = 0x0808 (PCM out), 0x1A = 0x0000 (record select mic).
REQ-006 Volume data for the first three entries is {3'b000, A, 3'b000, A}, where A = 5'd31 - Volume, computed in 5-bit unsigned arithmetic.
  - Example: Volume 22 gives A = 9, data = 0x0909.
REQ-007 Issue cycle: drive Register, command and validate=1 together.
  - All three stay stable until done or timeout.
  - validate falls on the cycle after done.
  - validate stays low for at least 1 cycle between commands.
REQ-008 INIT_WAIT advances on done. After entry 4, go to RUN_IDLE and set init_done=1; it stays 1 until reset or codec_ready falls.
REQ-009 RUN_IDLE arbitrates round-robin between requesters.
  - Priority pointer resets to requester 0 and toggles after each grant.
  - A single valid requester wins immediately.
  - Grant latency: the command is on the outputs 1 cycle after req_valid is sampled.
REQ-010 On grant, the address and data are latched internally. Requester inputs are ignored until ack.
REQ-011 RUN_WAIT: on done, pulse reqN_ack for 1 cycle and return to RUN_IDLE. A new grant is allowed no earlier than the following cycle.
REQ-012 Requesters hold valid until ack. The scheduler never acks a requester that is not granted.
REQ-013 Timeout: a counter loads 0 at issue and increments each waiting cycle. At count == TimeoutCycles-1 without done:
  - set timeout_err;
  - drop validate;
  - advance exactly as if done had arrived (next init entry, or ack the granted requester).
REQ-014 done and timeout in the same cycle count as done; timeout_err is not set.
REQ-015 done arriving while validate=0 is ignored.
REQ-016 codec_ready falling in any state: next cycle go to WAIT_READY.
  - validate=0 and init_done=0.
  - The pending request is dropped without ack and the pointer is reset.
  - The init table reruns on the next codec_ready.
REQ-017 busy = validate.

Reset
REQ-018 While Rst is sampled high, at the next CLK edge:
  - state = WAIT_READY;
  - validate, req0_ack, req1_ack, init_done, timeout_err = 0;
  - Register = 0x00, command = 0x0000;
  - table index, timeout counter and priority pointer = 0.
REQ-019 Reset mid-command abandons it with no ack. Reset is the only clear for timeout_err.

Structure
REQ-020 A shared package ac97_pkg holds:
  - register address constants (0x02, 0x04, 0x10, 0x18, 0x1A);
  - the state enum;
  - the init table length (5).
REQ-021 Sub-module ac97_rr_arbiter (2-way round-robin, grant plus pointer) is instantiated once. Everything else is flat.

Verification
REQ-022 Defaults with codec_ready high and done 10 cycles after each validate rise:
  - 5 writes in order: 0x02/0x0909, 0x04/0x0909, 0x10/0x0909, 0x18/0x0808, 0x1A/0x0000;
  - init_done=1 after the 5th done.
REQ-023 After init, req0 and req1 both valid, with addresses 0x02 and 0x04:
  - grant order req0, req1, req0;
  - each ack is 1 cycle wide, on the cycle after its done.
REQ-024 done withheld, TimeoutCycles=16:
  - validate falls 16 cycles after issue;
  - timeout_err=1;
  - the next init entry is issued after a gap of at least 1 cycle.
REQ-025 codec_ready dropped during RUN_WAIT for req1:
  - no req1_ack;
  - validate=0 next cycle;
  - the init table reissues from 0x02 after codec_ready returns.
REQ-026 Rst asserted in INIT_WAIT during entry 2:
  - all outputs reach their reset values 1 cycle later;
  - timeout_err cleared;
  - init restarts from entry 0.
REQ-027 done and timeout coincident: the command is acked and timeout_err stays 0.
